io_checkpoint_monitor: RTL and testbench
========================================

Name: io_checkpoint_monitor

Overview:
Synthesizable checkpoint sequencer in the user project area. It consumes the checkpoint word and status nibble that firmware drives onto mprj_io[31:16] and mprj_io[35:32]. It matches them in order against a programmed list of expected values, under a global timeout. It reports pass/fail in hardware, so that pad-level stimulus tests no longer need a bench-side monitor.

Parameters:
DEPTH, 8, number of expected-value table entries (power of two, 2..16)
STABLE_CYCLES, 4, consecutive identical samples required before a value counts as settled (1..255)
TIMEOUT_CYCLES, 150000, cycles from start to forced FAIL (fits in 32 bits)

Ports:
clock  input  1  system clock
resetb  input  1  asynchronous active-low reset
cfg_we  input  1  table write strobe
cfg_addr  input  $clog2(DEPTH)  table entry index
cfg_wdata  input  33  [32]=kind (0 checkbits, 1 status), [31:16]=alternate value, [15:0]=primary value
cfg_len  input  $clog2(DEPTH)+1  number of active entries (0..DEPTH), sampled at start
start  input  1  one-cycle pulse, arms the sequence
checkbits_in  input  16  asynchronous, from mprj_io[31:16]
status_in  input  4  asynchronous, from mprj_io[35:32]
busy  output  1  sequence in progress
pass  output  1  sticky, all entries matched
fail  output  1  sticky, timeout occurred
step  output  $clog2(DEPTH)+1  index of the entry currently awaited / entries matched
done_irq  output  1  one-cycle pulse on entry to PASS or FAIL

Behaviour:
- Reset (async, resetb low): state IDLE; busy=0, pass=0, fail=0, step=0, done_irq=0; sync/filter registers cleared; table contents undefined (not reset).
- Input path: 2-flop synchronizer on the 20 bits, followed by a stability filter.
  - Filter holds stable_cnt (saturating at STABLE_CYCLES) and compares each synchronized sample with the previous one.
  - Any bit change: stable_cnt <= 0.
  - settled=1 while stable_cnt==STABLE_CYCLES; settled_val is the value at that point.
  - Latency from pad change to compare: 2 + STABLE_CYCLES + 1 cycles.
- Table: written on cfg_we only in IDLE, PASS or FAIL; writes while busy are ignored.
- Match rule for entry i:
  - kind=0: settled && (cb==primary || cb==alternate).
  - kind=1: settled && (st==primary[3:0] || st==alternate[3:3-3+0]...) — i.e. st==primary[3:0] || st==alternate[3:0].
  - Set alternate=primary for an exact match.
- States:
  - IDLE: start -> ARM.
  - ARM (1 cycle): latch cfg_len; clear pass/fail; step=0; timer=0; busy=1. If len==0 -> PASS, else -> WAIT.
  - WAIT: timer increments every cycle.
    - Match on entry[step]: step<=step+1; if step+1==len -> PASS.
    - timer==TIMEOUT_CYCLES-1 without completing -> FAIL.
    - Match and timeout in the same cycle: match wins (PASS if it was the last entry); otherwise FAIL.
    - The next entry is evaluated from the following cycle. Consecutive entries satisfied by the same settled value match on consecutive cycles, with no new transition required.
  - PASS: pass=1, busy=0; done_irq high for the first cycle only. start -> ARM.
  - FAIL: fail=1, busy=0, step frozen at the failing index; done_irq high for the first cycle only. start -> ARM.
- start while busy: ignored.
- resetb asserted mid-sequence: immediate return to IDLE with all outputs 0.
- Values that appear and vanish within STABLE_CYCLES never match (glitch rejection across multi-bit transitions).

Decomposition:
- Shared package io_checkpoint_pkg holds:
  - state enum (IDLE, ARM, WAIT, PASS, FAIL);
  - cfg_wdata field offsets (KIND_BIT=32, ALT_MSB/LSB, PRI_MSB/LSB);
  - kind constants KIND_CHECK=0, KIND_STATUS=1.
- One sub-module, io_sample_filter (parameter WIDTH=20, STABLE_CYCLES):
  - inputs clock, resetb, raw[WIDTH-1:0];
  - outputs settled, settled_val[WIDTH-1:0].
- Table storage and FSM stay in the top module.

Test Plan:
- Program entries {0,AB40,AB40},{1,A,A},{1,5,5},{0,0840,0841},{0,0A00,0A01},{0,AB51,AB51}, len=6, start. Drive that sequence, each value held 20 cycles, with 0841 and 0A00 -> step 0..6, pass=1, fail=0, done_irq one pulse.
- Same table, drive AB40 then hold status=3 -> timer reaches TIMEOUT_CYCLES (override 1000) -> fail=1 at cycle 1000 after ARM, step=1, pass=0.
- Glitch: checkbits AB40 held for STABLE_CYCLES+1 cycles minus 2 (i.e. 3 cycles, STABLE_CYCLES=4) between 0000s -> step stays 0; held 8 cycles -> step=1 exactly 7 cycles after pad change.
- len=0, start -> pass=1 two cycles after start; done_irq pulses once.
- cfg_we to entry 0 and a second start while busy -> table and sequence unaffected; run completes with the original values.
- resetb low mid-WAIT at step=3 -> busy/pass/fail/step=0 immediately, asynchronously; after release, start rerun passes.

Source files
------------

// File: rtl/io_checkpoint_pkg.sv
// Shared types and cfg_wdata field layout for the checkpoint monitor.
// State encoding plus table entry kind constants.
package io_checkpoint_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT,
        PASS,
        FAIL
    } state_t;

    localparam int KIND_BIT = 32;
    localparam int ALT_MSB  = 31;
    localparam int ALT_LSB  = 16;
    localparam int PRI_MSB  = 15;
    localparam int PRI_LSB  = 0;

    localparam logic KIND_CHECK  = 1'b0;
    localparam logic KIND_STATUS = 1'b1;

endpackage

// File: rtl/io_sample_filter.sv
// Two-flop synchronizer plus stability filter for asynchronous pad inputs.
// Ports: clock, resetb, raw -> settled, settled_val.
module io_sample_filter #(
    parameter int WIDTH         = 20,
    parameter int STABLE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [WIDTH-1:0] raw,
    output logic             settled,
    output logic [WIDTH-1:0] settled_val
);

    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [7:0]       stable_cnt;
    logic [7:0]       cnt_next;

    // Any change restarts the count; identical samples count up and
    // saturate. settled looks at the count being loaded this cycle so
    // the consumer sees it without an extra register stage.
    always_comb begin
        cnt_next = stable_cnt;
        if (sync2 != prev)
            cnt_next = '0;
        else if (stable_cnt != STABLE)
            cnt_next = stable_cnt + 8'd1;
    end

    assign settled     = (cnt_next == STABLE);
    assign settled_val = sync2;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            sync1      <= '0;
            sync2      <= '0;
            prev       <= '0;
            stable_cnt <= '0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            prev       <= sync2;
            stable_cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/io_checkpoint_monitor.sv
// Ordered checkpoint matcher for firmware-driven pad values with timeout.
// Ports: cfg_* table/length, start, pad inputs -> busy/pass/fail/step/irq.
module io_checkpoint_monitor
    import io_checkpoint_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 150000
) (
    input  logic                     clock,
    input  logic                     resetb,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [32:0]              cfg_wdata,
    input  logic [$clog2(DEPTH):0]   cfg_len,
    input  logic                     start,
    input  logic [15:0]              checkbits_in,
    input  logic [3:0]               status_in,
    output logic                     busy,
    output logic                     pass,
    output logic                     fail,
    output logic [$clog2(DEPTH):0]   step,
    output logic                     done_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = AW + 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t state;
    state_t state_next;

    logic [32:0]   tbl [DEPTH];
    logic [SW-1:0] len_q;
    logic [SW-1:0] step_next;
    logic [SW-1:0] step_inc;
    logic [31:0]   timer;
    logic          irq_next;

    logic          settled;
    logic [19:0]   settled_val;
    logic [32:0]   entry;
    logic [15:0]   pri;
    logic [15:0]   alt;
    logic [15:0]   cb;
    logic [3:0]    st;
    logic          hit;
    logic          match;

    io_sample_filter #(
        .WIDTH        (20),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clock      (clock),
        .resetb     (resetb),
        .raw        ({status_in, checkbits_in}),
        .settled    (settled),
        .settled_val(settled_val)
    );

    assign busy = (state == ARM) || (state == WAIT);
    assign pass = (state == PASS);
    assign fail = (state == FAIL);

    // Table is frozen while a sequence runs.
    always_ff @(posedge clock) begin
        if (cfg_we && !busy)
            tbl[cfg_addr] <= cfg_wdata;
    end

    assign entry = tbl[step[AW-1:0]];
    assign pri   = entry[PRI_MSB:PRI_LSB];
    assign alt   = entry[ALT_MSB:ALT_LSB];
    assign cb    = settled_val[15:0];
    assign st    = settled_val[19:16];

    always_comb begin
        hit = 1'b0;
        if (entry[KIND_BIT] == KIND_STATUS)
            hit = (st == pri[3:0]) || (st == alt[3:0]);
        else
            hit = (cb == pri) || (cb == alt);
    end

    assign match    = settled && hit;
    assign step_inc = step + SW'(1);

    always_comb begin
        state_next = state;
        step_next  = step;
        unique case (state)
            IDLE, PASS, FAIL: begin
                if (start) begin
                    state_next = ARM;
                    step_next  = '0;
                end
            end
            ARM: begin
                if (cfg_len == '0)
                    state_next = PASS;
                else
                    state_next = WAIT;
            end
            WAIT: begin
                // A match in the timeout cycle still counts.
                if (match) begin
                    step_next = step_inc;
                    if (step_inc == len_q)
                        state_next = PASS;
                end else if (timer == TO_LAST) begin
                    state_next = FAIL;
                end
            end
            default: state_next = IDLE;
        endcase
        irq_next = busy &&
                   ((state_next == PASS) || (state_next == FAIL));
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state    <= IDLE;
            step     <= '0;
            len_q    <= '0;
            timer    <= '0;
            done_irq <= 1'b0;
        end else begin
            state    <= state_next;
            step     <= step_next;
            done_irq <= irq_next;
            if (state == ARM)
                len_q <= cfg_len;
            // Timer counts from the start edge, so ARM is cycle 0.
            if (state_next == ARM)
                timer <= '0;
            else if (busy)
                timer <= timer + 32'd1;
        end
    end

endmodule

// File: tb/tb_io_checkpoint_monitor.sv
// Directed self-checking bench for io_checkpoint_monitor.
// Scenario tasks run in sequence from one initial block.
module tb_io_checkpoint_monitor;

    logic        clock;
    logic        resetb;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [32:0] cfg_wdata;
    logic [3:0]  cfg_len;
    logic        start;
    logic [19:0] pad;
    logic        busy;
    logic        pass;
    logic        fail;
    logic [3:0]  step;
    logic        done_irq;

    int checks = 0;
    int errors = 0;
    int irq_cnt = 0;
    int irq0;

    logic [32:0] ents [6] = '{
        33'h0_AB40_AB40, 33'h1_000A_000A,
        33'h1_0005_0005, 33'h0_0841_0840,
        33'h0_0A01_0A00, 33'h0_AB51_AB51
    };
    logic [19:0] pads [6] = '{
        20'h0_AB40, 20'hA_AB40, 20'h5_AB40,
        20'h5_0841, 20'h5_0A00, 20'h5_AB51
    };

    io_checkpoint_monitor #(
        .DEPTH         (8),
        .STABLE_CYCLES (4),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clock       (clock),
        .resetb      (resetb),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_len     (cfg_len),
        .start       (start),
        .checkbits_in(pad[15:0]),
        .status_in   (pad[19:16]),
        .busy        (busy),
        .pass        (pass),
        .fail        (fail),
        .step        (step),
        .done_irq    (done_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock)
        if (done_irq === 1'b1) irq_cnt++;

    task automatic start_pulse();
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
    endtask

    task automatic settle_zero();
        @(negedge clock);
        pad = '0;
        repeat (10) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        resetb = 1'b0;
        repeat (2) @(negedge clock);
        resetb = 1'b1;
    endtask

    task automatic program_table();
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            cfg_we    = 1'b1;
            cfg_addr  = 3'(i);
            cfg_wdata = ents[i];
        end
        @(negedge clock);
        cfg_we = 1'b0;
    endtask

    task automatic drive_values(int first, int last);
        for (int i = first; i < last; i++) begin
            @(negedge clock);
            pad = pads[i];
            repeat (20) @(negedge clock);
            checks++;
            if (step !== 4'(i + 1)) begin
                errors++;
                $display("FAIL step_after_value%0d: got %0d want %0d",
                         i, step, i + 1);
            end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({busy, pass, fail, step, done_irq} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got b%0b p%0b f%0b s%0d i%0b want 0",
                     busy, pass, fail, step, done_irq);
        end
        @(negedge clock);
        resetb = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({busy, pass, fail, step} !== 7'h00) begin
            errors++;
            $display("FAIL idle_after_reset: got b%0b p%0b f%0b s%0d want 0",
                     busy, pass, fail, step);
        end
    endtask

    task automatic test_sequence();
        program_table();
        cfg_len = 4'd6;
        settle_zero();
        irq0 = irq_cnt;
        start_pulse();
        checks++;
        if (busy !== 1'b1 || step !== 4'd0) begin
            errors++;
            $display("FAIL seq_armed: got busy %0b step %0d want 1 0",
                     busy, step);
        end
        drive_values(0, 6);
        checks++;
        if ({pass, fail, busy} !== 3'b100) begin
            errors++;
            $display("FAIL seq_pass: got p%0b f%0b b%0b want p1 f0 b0",
                     pass, fail, busy);
        end
        checks++;
        if (irq_cnt - irq0 !== 1) begin
            errors++;
            $display("FAIL seq_irq_count: got %0d want 1", irq_cnt - irq0);
        end
    endtask

    task automatic test_timeout();
        @(negedge clock);
        pad = 20'h3_AB40;
        start_pulse();
        repeat (999) @(posedge clock);
        #1;
        checks++;
        if (fail !== 1'b0 || step !== 4'd1) begin
            errors++;
            $display("FAIL to_before: got fail %0b step %0d want 0 1",
                     fail, step);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({fail, pass, busy, done_irq} !== 4'b1001 || step !== 4'd1) begin
            errors++;
            $display("FAIL to_at_1000: got f%0b p%0b b%0b i%0b s%0d want f1 p0 b0 i1 s1",
                     fail, pass, busy, done_irq, step);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        settle_zero();
        cfg_len = 4'd6;
        start_pulse();
        repeat (3) @(negedge clock);
        pad = 20'h0_AB40;
        repeat (3) @(negedge clock);
        pad = '0;
        repeat (20) @(negedge clock);
        checks++;
        if (step !== 4'd0) begin
            errors++;
            $display("FAIL glitch_rejected: got step %0d want 0", step);
        end
        @(negedge clock);
        pad = 20'h0_AB40;
        repeat (6) @(posedge clock);
        #1;
        checks++;
        if (step !== 4'd0) begin
            errors++;
            $display("FAIL glitch_edge6: got step %0d want 0", step);
        end
        @(posedge clock);
        #1;
        checks++;
        if (step !== 4'd1) begin
            errors++;
            $display("FAIL glitch_edge7: got step %0d want 1", step);
        end
        do_reset();
    endtask

    task automatic test_len_zero();
        cfg_len = 4'd0;
        irq0 = irq_cnt;
        start_pulse();
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL len0_arm: got busy %0b pass %0b want 1 0",
                     busy, pass);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({pass, busy, done_irq} !== 3'b101) begin
            errors++;
            $display("FAIL len0_pass: got p%0b b%0b i%0b want p1 b0 i1",
                     pass, busy, done_irq);
        end
        repeat (5) @(negedge clock);
        checks++;
        if (irq_cnt - irq0 !== 1 || pass !== 1'b1) begin
            errors++;
            $display("FAIL len0_irq_once: got irqs %0d pass %0b want 1 1",
                     irq_cnt - irq0, pass);
        end
    endtask

    task automatic test_busy_ignore();
        cfg_len = 4'd6;
        settle_zero();
        start_pulse();
        drive_values(0, 1);
        @(negedge clock);
        cfg_we    = 1'b1;
        cfg_addr  = 3'd0;
        cfg_wdata = 33'h0_1234_1234;
        start     = 1'b1;
        @(negedge clock);
        cfg_we = 1'b0;
        start  = 1'b0;
        repeat (5) @(negedge clock);
        checks++;
        if (step !== 4'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: got step %0d busy %0b want 1 1",
                     step, busy);
        end
        drive_values(1, 6);
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL busy_run_pass: got pass %0b want 1", pass);
        end
        settle_zero();
        start_pulse();
        drive_values(0, 1);
        do_reset();
    endtask

    task automatic test_reset_mid();
        cfg_len = 4'd6;
        settle_zero();
        start_pulse();
        drive_values(0, 3);
        @(negedge clock);
        #2 resetb = 1'b0;
        #1;
        checks++;
        if ({busy, pass, fail, step, done_irq} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got b%0b p%0b f%0b s%0d i%0b want 0",
                     busy, pass, fail, step, done_irq);
        end
        @(negedge clock);
        resetb = 1'b1;
        settle_zero();
        start_pulse();
        drive_values(0, 6);
        checks++;
        if ({pass, fail, busy} !== 3'b100) begin
            errors++;
            $display("FAIL rerun_pass: got p%0b f%0b b%0b want p1 f0 b0",
                     pass, fail, busy);
        end
    endtask

    initial begin
        resetb    = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_wdata = '0;
        cfg_len   = '0;
        start     = 1'b0;
        pad       = '0;
        test_reset();
        test_sequence();
        test_timeout();
        test_glitch();
        test_len_zero();
        test_busy_ignore();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
